fifo_buffer: RTL and testbench

//   Synchronous first-in-first-out queue; counterpart to the team's LIFO stack.

---
 rtl/fifo_buffer.sv | 73 +++++++
 tb/tb_fifo_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with circular storage, occupancy count,
// level flags and sticky overflow/underflow error flags.
module fifo_buffer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wn,
    input  logic              rn,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CMAX = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == CMAX);
    assign empty = (count == '0);

    // A read while full frees the slot the same-cycle write lands in
    assign do_wr = wn && (!full || rn);
    assign do_rd = rn && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                out    <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
            if (wn && full && !rn) begin
                overflow <= 1'b1;
            end
            if (rn && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            mem[wr_ptr] <= in;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Testbench for fifo_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fifo_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wn = 1'b0;
    logic              rn = 1'b0;
    logic [WIDTH-1:0]  in = '0;
    logic [WIDTH-1:0]  out;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_out = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    fifo_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wn       (wn),
        .rn       (rn),
        .in       (in),
        .out      (out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r_, input logic w_,
                         input logic rd_, input logic [WIDTH-1:0] d);
        int n;
        bit rd_ok;
        bit wr_ok;
        n = q.size();
        if (r_) begin
            q.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = rd_ && (n > 0);
            wr_ok = w_ && ((n < DEPTH) || rd_);
            if (w_ && n == DEPTH && !rd_) m_ovf = 1'b1;
            if (rd_ && n == 0) m_unf = 1'b1;
            if (rd_ok) m_out = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    task automatic step(input logic r_, input logic w_,
                        input logic rd_, input logic [WIDTH-1:0] d);
        rst = r_;
        wn  = w_;
        rn  = rd_;
        in  = d;
        @(posedge clk);
        model(r_, w_, rd_, d);
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic reset();
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        automatic logic [WIDTH-1:0] t1[7] = '{100, 150, 200, 40, 70, 65, 15};
        automatic logic [WIDTH-1:0] t3[8] = '{13, 14, 20, 21, 22, 23, 24, 25};

        reset();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_out", 32'(out), 0);

        foreach (t1[i]) wr(t1[i]);
        chk("t1_count", 32'(count), 7);
        chk("t1_full", 32'(full), 0);
        foreach (t1[i]) begin
            rd();
            chk("t1_out", 32'(out), 32'(t1[i]));
        end
        chk("t1_empty", 32'(empty), 1);

        reset();
        for (int i = 1; i <= 8; i++) wr(WIDTH'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 8);
        wr(9);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_count9", 32'(count), 8);
        for (int i = 1; i <= 8; i++) begin
            rd();
            chk("t2_out", 32'(out), 32'(i));
        end
        chk("t2_empty", 32'(empty), 1);

        reset();
        for (int i = 10; i <= 14; i++) wr(WIDTH'(i));
        for (int i = 10; i <= 12; i++) begin
            rd();
            chk("t3_out", 32'(out), 32'(i));
        end
        for (int i = 20; i <= 25; i++) wr(WIDTH'(i));
        chk("t3_full", 32'(full), 1);
        foreach (t3[i]) begin
            rd();
            chk("t3_drain", 32'(out), 32'(t3[i]));
        end

        reset();
        for (int i = 1; i <= 8; i++) wr(WIDTH'(i));
        step(1'b0, 1'b1, 1'b1, 99);
        chk("t4_out", 32'(out), 1);
        chk("t4_count", 32'(count), 8);
        chk("t4_ovf", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) rd();
        chk("t4_last", 32'(out), 99);
        step(1'b0, 1'b1, 1'b1, 5);
        chk("t4e_out", 32'(out), 99);
        chk("t4e_unf", 32'(underflow), 1);
        chk("t4e_count", 32'(count), 1);

        reset();
        rd();
        chk("t5_out", 32'(out), 0);
        chk("t5_unf", 32'(underflow), 1);
        chk("t5_count", 32'(count), 0);
        wr(7);
        rd();
        chk("t5_out7", 32'(out), 7);
        chk("t5_unf2", 32'(underflow), 1);

        wr(1);
        wr(2);
        wr(3);
        reset();
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_out", 32'(out), 0);
        chk("t6_flags", 32'({overflow, underflow}), 0);
        wr(42);
        rd();
        chk("t6_out42", 32'(out), 42);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 45),
                 WIDTH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
